// File: rtl/shift_pkg.sv
// Shared encodings and control payload for the shift_pipe pipeline.
// Mode 11 is a right rotate only when SHIFT_PIPE_ROTATE_EN is defined.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_SRL  = 2'b00,
        MODE_SLL  = 2'b01,
        MODE_SRA  = 2'b10,
        MODE_ROTR = 2'b11
    } mode_t;

    typedef struct packed {
        mode_t mode;
        logic  enable;
    } ctrl_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter level: fixed shift by SI for the selected mode, applied when sel is set.
// Mode 11 rotates right with SHIFT_PIPE_ROTATE_EN defined, otherwise it yields zero.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SI    = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  mode_t            mode,
    input  logic             sel,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] shifted;

    // SRA keeps the MSB, so the original sign propagates through every level.
    always_comb begin
        shifted = data_in;
        case (mode)
            MODE_SRL: shifted = data_in >> SI;
            MODE_SLL: shifted = data_in << SI;
            MODE_SRA: shifted = WIDTH'($signed(data_in) >>> SI);
`ifdef SHIFT_PIPE_ROTATE_EN
            MODE_ROTR: shifted = {data_in[SI-1:0], data_in[WIDTH-1:SI]};
`else
            MODE_ROTR: shifted = '0;
`endif
            default: shifted = data_in;
        endcase
    end

    assign data_out = sel ? shifted : data_in;

endmodule

// File: rtl/shift_pipe.sv
// Elastic log2(WIDTH)-stage shifter pipeline with valid/ready handshake on both sides.
// Build option: SHIFT_PIPE_ROTATE_EN turns mode 11 into a right rotate.
module shift_pipe
    import shift_pkg::*;
#(
    parameter  int unsigned WIDTH  = 32,
    localparam int unsigned STAGES = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [STAGES-1:0] in_shamt,
    input  logic [1:0]        in_mode,
    input  logic              in_enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data
);

    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  dat  [STAGES];
    logic [STAGES-1:0] sh   [STAGES];
    ctrl_t             ctl  [STAGES];

    logic [STAGES-1:0] vin;
    logic [WIDTH-1:0]  din  [STAGES];
    logic [STAGES-1:0] shin [STAGES];
    ctrl_t             cin  [STAGES];
    logic [WIDTH-1:0]  nxt  [STAGES];
    logic [STAGES-1:0] ld;

    // Remaining shamt is kept right-aligned: bit 0 always belongs to the stage it enters.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign vin[s]  = in_valid;
            assign din[s]  = in_data;
            assign shin[s] = in_shamt;
            assign cin[s]  = '{mode: mode_t'(in_mode), enable: in_enable};
        end else begin : g_body
            assign vin[s]  = vld[s-1];
            assign din[s]  = dat[s-1];
            assign shin[s] = sh[s-1];
            assign cin[s]  = ctl[s-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .SI    (1 << s)
        ) u_stage (
            .data_in  (din[s]),
            .mode     (cin[s].mode),
            .sel      (cin[s].enable & shin[s][0]),
            .data_out (nxt[s])
        );
    end

    // A stage may load if the output drains or any stage from here onward has a hole.
    always_comb begin
        ld = '0;
        for (int s = 0; s < STAGES; s++) begin
            ld[s] = out_ready || (((~vld) >> s) != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int s = 0; s < STAGES; s++) begin
                dat[s] <= '0;
                sh[s]  <= '0;
                ctl[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (ld[s]) begin
                    vld[s] <= vin[s];
                    if (vin[s]) begin
                        dat[s] <= nxt[s];
                        sh[s]  <= shin[s] >> 1;
                        ctl[s] <= cin[s];
                    end
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = vld[STAGES-1];
    assign out_data  = dat[STAGES-1];

    // Control carried into the final stage has no consumer.
    logic unused_tail;
    assign unused_tail = ^{sh[STAGES-1], ctl[STAGES-1]};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=32): vector table, directed corner sequences,
// randomized traffic against an arithmetic reference model and an in-order scoreboard.
module tb_shift_pipe;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [4:0]   in_shamt;
    logic [1:0]   in_mode;
    logic         in_enable;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .in_enable (in_enable),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    typedef struct {
        logic [W-1:0] data;
        logic [4:0]   shamt;
        logic [1:0]   mode;
        logic         en;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference: shift semantics straight from the mode definitions.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int sh,
                                           input logic [1:0] m, input logic en);
        if (!en || sh == 0) return d;
        case (m)
            2'b00: return d >> sh;
            2'b01: return d << sh;
            2'b10: return W'($signed(d) >>> sh);
            default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
                return (d >> sh) | (d << (W - sh));
`else
                return '0;
`endif
            end
        endcase
    endfunction

    // Scoreboard: accepted operands queue their expected result; delivered results pop in order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %h with no operand outstanding", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("scoreboard", out_data, mon_exp);
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_data, int'(in_shamt), in_mode, in_enable));
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [4:0] sh,
                        input logic [1:0] m, input logic en);
        int w = 0;
        @(posedge clk); #2;
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = sh;
        in_mode   = m;
        in_enable = en;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) timeout("send");
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [W-1:0] d, output bit ok);
        int w = 0;
        @(negedge clk);
        while (!out_valid && w < 30) begin
            @(negedge clk);
            w++;
        end
        ok = out_valid;
        d  = out_data;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] got;
        bit           ok;
        int           acc;
        int           cnt;
        int           sent;
        int           cyc;
        bit           acc_last;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_shamt = '0;
        in_mode = '0;
        in_enable = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", W'(out_valid), 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", W'(in_ready), 1);

        // SRA latency: valid exactly on the fifth edge counting the acceptance edge
        send(32'h80000010, 5'd4, 2'b10, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("lat_valid_c%0d", k), W'(out_valid), (k == 5) ? 1 : 0);
        end
        check("lat_data", out_data, 32'hF8000001);

        // Vector table
        vecs[0] = '{32'hF0000000, 5'd4,  2'b00, 1'b1, 32'h0F000000};
        vecs[1] = '{32'h0000000F, 5'd28, 2'b01, 1'b1, 32'hF0000000};
        vecs[2] = '{32'h80000000, 5'd31, 2'b10, 1'b1, 32'hFFFFFFFF};
        vecs[3] = '{32'h40000000, 5'd30, 2'b10, 1'b1, 32'h00000001};
        vecs[4] = '{32'hDEADBEEF, 5'd0,  2'b00, 1'b1, 32'hDEADBEEF};
        vecs[5] = '{32'hDEADBEEF, 5'd31, 2'b10, 1'b0, 32'hDEADBEEF};
        vecs[6] = '{32'h12345679, 5'd31, 2'b01, 1'b1, 32'h80000000};
`ifdef SHIFT_PIPE_ROTATE_EN
        vecs[7] = '{32'h12345678, 5'd8,  2'b11, 1'b1, 32'h78123456};
`else
        vecs[7] = '{32'h12345678, 5'd8,  2'b11, 1'b1, 32'h00000000};
`endif
        vecs[8] = '{32'h12345678, 5'd0,  2'b11, 1'b1, 32'h12345678};
        vecs[9] = '{32'h80000000, 5'd31, 2'b00, 1'b1, 32'h00000001};
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].data, vecs[i].shamt, vecs[i].mode, vecs[i].en);
            wait_out(got, ok);
            if (!ok) timeout($sformatf("vec%0d", i));
            else     check($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Back-to-back SLL 1<<k, no bubbles
        fork
            begin
                for (int k = 0; k < 32; k++) begin
                    @(posedge clk); #2;
                    in_valid  = 1'b1;
                    in_data   = 32'h1;
                    in_shamt  = 5'(k);
                    in_mode   = 2'b01;
                    in_enable = 1'b1;
                end
                @(posedge clk); #2;
                in_valid = 1'b0;
            end
            begin
                int w = 0;
                @(negedge clk);
                while (!out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                for (int k = 0; k < 32; k++) begin
                    logic [W-1:0] one = 32'h1;
                    check($sformatf("b2b_valid%0d", k), W'(out_valid), 1);
                    check($sformatf("b2b_data%0d", k), out_data, one << k);
                    @(negedge clk);
                end
            end
        join

        // Backpressure: six offered, five fit, output held, all delivered in order
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #2;
            out_ready = 1'b0;
            in_valid  = (acc < 6);
            in_data   = 32'(acc + 1) * 32'h11111111;
            in_shamt  = 5'(acc + 1);
            in_mode   = 2'b00;
            in_enable = 1'b1;
            @(negedge clk);
            if (out_valid) check("bp_hold", out_data, model(32'h11111111, 1, 2'b00, 1'b1));
            if (in_valid && in_ready) acc++;
        end
        check("bp_accepted", 32'(acc), 5);
        check("bp_in_ready", W'(in_ready), 0);
        check("bp_out_valid", W'(out_valid), 1);
        @(posedge clk); #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("bp_delivered", 32'(cnt), 5);

        // Randomized traffic with random stalls on both sides
        sent = 0;
        cyc = 0;
        acc_last = 1'b0;
        while (sent < 300 && cyc < 5000) begin
            @(posedge clk); #2;
            if (!in_valid || acc_last) begin
                if ($urandom_range(0, 9) < 7) begin
                    in_valid  = 1'b1;
                    in_data   = $urandom;
                    in_shamt  = 5'($urandom_range(0, 31));
                    in_mode   = 2'($urandom_range(0, 3));
                    in_enable = ($urandom_range(0, 7) != 0);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc_last = in_valid && in_ready;
            if (acc_last) sent++;
            cyc++;
        end
        if (sent < 300) timeout("random_send");
        @(posedge clk); #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("random_drain", 32'(exp_q.size()), 0);

        // Reset mid-stream with three operations in flight, output stalled
        @(posedge clk); #2;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid  = 1'b1;
            in_data   = 32'hA5A5_0000 + 32'(k);
            in_shamt  = 5'd1;
            in_mode   = 2'b01;
            in_enable = 1'b1;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("pre_rst_valid", W'(out_valid), 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", W'(out_valid), 0);
        check("async_rst_data", out_data, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", W'(in_ready), 1);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("post_rst_idle%0d", c), W'(out_valid), 0);
            @(negedge clk);
        end
        check("final_queue", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
